// File: rtl/mem_access_pkg.sv
// Shared types and constants for the data-memory access unit and its lane aligner.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StResp
  } state_e;

  localparam logic [31:0] DATA_BASE = 32'h0001_0000;
  localparam logic [31:0] DATA_TOP  = 32'h0001_FFFF;

  // Reserved size counts as misaligned so it takes the same error path.
  function automatic logic misaligned(size_e size, logic [1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [2:0] size_bytes(size_e size);
    logic [2:0] n;
    case (size)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane aligner: extracts and extends a load lane from a RAM word and
// merges a right-justified store lane back into a word. Little-endian lane numbering.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic [$clog2(DATA_WIDTH/BYTE_WIDTH)-1:0] offset,
  input  size_e                                    size,
  input  logic                                     is_unsigned,
  input  logic [DATA_WIDTH-1:0]                    word,
  input  logic [DATA_WIDTH-1:0]                    wdata,
  output logic [DATA_WIDTH-1:0]                    load_data,
  output logic [DATA_WIDTH-1:0]                    store_word
);

  localparam int unsigned BitW  = $clog2(DATA_WIDTH);
  localparam int unsigned HalfW = 2 * BYTE_WIDTH;

  logic [BitW-1:0]       shamt;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] lane_mask;

  assign shamt = BitW'(offset) << $clog2(BYTE_WIDTH);

  always_comb begin
    shifted   = word >> shamt;
    lane_mask = '0;
    load_data = shifted;
    unique case (size)
      SZ_B: begin
        lane_mask[BYTE_WIDTH-1:0] = '1;
        load_data = {{(DATA_WIDTH-BYTE_WIDTH){~is_unsigned & shifted[BYTE_WIDTH-1]}},
                     shifted[BYTE_WIDTH-1:0]};
      end
      SZ_H: begin
        lane_mask[HalfW-1:0] = '1;
        load_data = {{(DATA_WIDTH-HalfW){~is_unsigned & shifted[HalfW-1]}},
                     shifted[HalfW-1:0]};
      end
      SZ_W:    lane_mask = '1;
      default: lane_mask = '0;
    endcase
    // A full-word mask discards the old word, so word stores need no prior read.
    store_word = (word & ~(lane_mask << shamt)) | ((wdata & lane_mask) << shamt);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-wide data RAM: aligns addresses, extends loads and
// does read-modify-write for sub-word stores. Optional address window check under
// the MEM_RANGE_CHECK_EN macro.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] mem_r_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic [DATA_WIDTH-1:0] mem_w_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_we
);

  localparam int unsigned OffW = $clog2(DATA_WIDTH/BYTE_WIDTH);

  state_e                state_q;
  logic                  we_q;
  logic                  uns_q;
  size_e                 size_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  size_e                 req_size_e;
  logic                  req_err;
  logic [DATA_WIDTH-1:0] aligned_addr;
  logic [DATA_WIDTH-1:0] align_word;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_word;

  assign req_size_e = size_e'(req_size);

`ifdef MEM_RANGE_CHECK_EN
  localparam int unsigned AddrW1 = DATA_WIDTH + 1;

  logic [DATA_WIDTH:0] last_byte;
  logic                out_of_range;

  // One extra bit so a request wrapping past the top of the address space is caught.
  assign last_byte    = {1'b0, req_addr} + AddrW1'(size_bytes(req_size_e) - 3'd1);
  assign out_of_range = (req_addr < DATA_WIDTH'(DATA_BASE)) ||
                        (last_byte > {1'b0, DATA_WIDTH'(DATA_TOP)});
  assign req_err      = misaligned(req_size_e, req_addr[1:0]) | out_of_range;
`else
  assign req_err      = misaligned(req_size_e, req_addr[1:0]);
`endif

  assign aligned_addr = {addr_q[DATA_WIDTH-1:OffW], {OffW{1'b0}}};
  // In RD the lane is taken straight from the RAM; in WR the captured word is merged.
  assign align_word   = (state_q == StRd) ? mem_rd : word_q;

  mem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_lane_align (
    .offset      (addr_q[OffW-1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .word        (align_word),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size_e;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= req_err;
            rdata_q <= '0;
            if (req_err) begin
              state_q <= StResp;
            end else if (req_we && (req_size_e == SZ_W)) begin
              state_q <= StWr;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: begin
          word_q <= mem_rd;
          if (we_q) begin
            state_q <= StWr;
          end else begin
            rdata_q <= load_data;
            state_q <= StResp;
          end
        end
        StWr: begin
          state_q <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake and RAM strobes decode the state register so reset kills them at once.
  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_we     = (state_q == StWr);
  assign mem_wd     = mem_we ? store_word : '0;
  assign mem_r_addr = (state_q != StIdle) ? aligned_addr : '0;
  assign mem_w_addr = (state_q != StIdle) ? aligned_addr : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a small word RAM model and a response
// scoreboard. Define MEM_RANGE_CHECK_EN to also exercise the address window check.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_r_addr;
  logic [31:0] mem_rd;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_wd;
  logic        mem_we;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          we_cnt = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;
  logic [31:0] ram [64];

  always #5 clk = ~clk;

  mem_access_unit #(
    .DATA_WIDTH (32),
    .BYTE_WIDTH (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_r_addr   (mem_r_addr),
    .mem_rd       (mem_rd),
    .mem_w_addr   (mem_w_addr),
    .mem_wd       (mem_wd),
    .mem_we       (mem_we)
  );

  assign mem_rd = ram[mem_r_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_w_addr[7:2]] <= mem_wd;
      we_cnt  <= we_cnt + 1;
      last_wa <= mem_w_addr;
      last_wd <= mem_wd;
    end
  end

  task automatic run_req(input string name, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_cyc, input int exp_writes, input int hold);
    exp_t e;
    int   cyc;
    int   wc;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb_q.push_back(e);
    wc = we_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL %s req_ready before accept: got %b want 1", name, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (resp_valid !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb_q.pop_front();
    total++;
    if (resp_valid !== 1'b1) begin
      bad++; $display("FAIL %s response timeout: got resp_valid=%b want 1", name, resp_valid);
      return;
    end
    total++;
    if (cyc !== exp_cyc) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_cyc);
    end
    if (hold > 0) resp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s hold %0d: got valid=%b rdata=%h ready=%b want 1 %h 0",
                 name, i, resp_valid, resp_rdata, req_ready, e.rdata);
      end
    end
    resp_ready = 1'b1;
    total++;
    if (resp_rdata !== e.rdata) begin
      bad++; $display("FAIL %s rdata: got %h want %h", name, resp_rdata, e.rdata);
    end
    total++;
    if (resp_err !== e.err) begin
      bad++; $display("FAIL %s err: got %b want %b", name, resp_err, e.err);
    end
    @(posedge clk); #1;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s retire: got valid=%b ready=%b want 0 1", name, resp_valid, req_ready);
    end
    total++;
    if (we_cnt - wc !== exp_writes) begin
      bad++; $display("FAIL %s write pulses: got %0d want %0d", name, we_cnt - wc, exp_writes);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin
      bad++; $display("FAIL reset handshake: got ready=%b valid=%b err=%b want 1 0 0",
                      req_ready, resp_valid, resp_err);
    end
    total++;
    if (resp_rdata !== 32'h0 || mem_we !== 1'b0 || mem_wd !== 32'h0) begin
      bad++; $display("FAIL reset data: got rdata=%h we=%b wd=%h want 0 0 0",
                      resp_rdata, mem_we, mem_wd);
    end
    total++;
    if (mem_r_addr !== 32'h0 || mem_w_addr !== 32'h0) begin
      bad++; $display("FAIL reset addr: got r=%h w=%h want 0 0", mem_r_addr, mem_w_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_store;
    run_req("st_w", 1'b1, 32'h0001_0000, 2'b10, 1'b0, 32'h8899_AABB, 32'h0, 1'b0, 2, 1, 0);
    total++;
    if (last_wa !== 32'h0001_0000 || last_wd !== 32'h8899_AABB) begin
      bad++; $display("FAIL st_w ram write: got %h/%h want 00010000/8899aabb", last_wa, last_wd);
    end
  endtask

  task automatic test_loads;
    run_req("ld_b_s", 1'b0, 32'h0001_0002, 2'b00, 1'b0, 32'h0, 32'hFFFF_FF99, 1'b0, 2, 0, 0);
    run_req("ld_h_u", 1'b0, 32'h0001_0002, 2'b01, 1'b1, 32'h0, 32'h0000_8899, 1'b0, 2, 0, 0);
    run_req("ld_w",   1'b0, 32'h0001_0000, 2'b10, 1'b0, 32'h0, 32'h8899_AABB, 1'b0, 2, 0, 0);
    run_req("ld_b_u", 1'b0, 32'h0001_0000, 2'b00, 1'b1, 32'h0, 32'h0000_00BB, 1'b0, 2, 0, 0);
    run_req("ld_h_s", 1'b0, 32'h0001_0000, 2'b01, 1'b0, 32'h0, 32'hFFFF_AABB, 1'b0, 2, 0, 0);
    run_req("ld_b3",  1'b0, 32'h0001_0003, 2'b00, 1'b0, 32'h0, 32'hFFFF_FF88, 1'b0, 2, 0, 0);
  endtask

  task automatic test_subword_store;
    run_req("st_b", 1'b1, 32'h0001_0001, 2'b00, 1'b0, 32'h1234_565A, 32'h0, 1'b0, 3, 1, 0);
    total++;
    if (last_wa !== 32'h0001_0000 || last_wd !== 32'h8899_5ABB) begin
      bad++; $display("FAIL st_b ram write: got %h/%h want 00010000/88995abb", last_wa, last_wd);
    end
    run_req("ld_after_b", 1'b0, 32'h0001_0000, 2'b10, 1'b0, 32'h0, 32'h8899_5ABB, 1'b0, 2, 0, 0);
    run_req("st_w4", 1'b1, 32'h0001_0004, 2'b10, 1'b0, 32'h1122_3344, 32'h0, 1'b0, 2, 1, 0);
    run_req("st_h", 1'b1, 32'h0001_0006, 2'b01, 1'b0, 32'hCAFE_BEEF, 32'h0, 1'b0, 3, 1, 0);
    run_req("ld_after_h", 1'b0, 32'h0001_0004, 2'b10, 1'b0, 32'h0, 32'hBEEF_3344, 1'b0, 2, 0, 0);
  endtask

  task automatic test_errors;
    run_req("err_ld_w", 1'b0, 32'h0001_0002, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    run_req("err_st_h", 1'b1, 32'h0001_0003, 2'b01, 1'b0, 32'hFFFF, 32'h0, 1'b1, 1, 0, 0);
    run_req("err_rsv",  1'b1, 32'h0001_0000, 2'b11, 1'b0, 32'h1, 32'h0, 1'b1, 1, 0, 0);
  endtask

  task automatic test_backpressure;
    run_req("hold_ld", 1'b0, 32'h0001_0000, 2'b00, 1'b0, 32'h0, 32'hFFFF_FFBB, 1'b0, 2, 0, 5);
  endtask

  task automatic test_back_to_back;
    int acc = 0;
    int rsp = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0001_0000; req_size = 2'b10;
    req_unsigned = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (req_valid && req_ready) acc++;
      if (resp_valid && resp_ready) rsp++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    total++;
    if (acc !== 3 || rsp !== 3) begin
      bad++; $display("FAIL b2b throughput: got acc=%0d rsp=%0d want 3 3", acc, rsp);
    end
  endtask

  task automatic test_reset_in_wr;
    int wc;
    wc = we_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0001_0004; req_size = 2'b00;
    req_unsigned = 1'b0; req_wdata = 32'h0000_0077;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (mem_we !== 1'b1) begin
      bad++; $display("FAIL rst_wr setup: got mem_we=%b want 1", mem_we);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_we !== 1'b0 || mem_wd !== 32'h0 || mem_w_addr !== 32'h0) begin
      bad++; $display("FAIL rst_wr strobe: got we=%b wd=%h wa=%h want 0 0 0",
                      mem_we, mem_wd, mem_w_addr);
    end
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 ||
        resp_rdata !== 32'h0 || mem_r_addr !== 32'h0) begin
      bad++; $display("FAIL rst_wr outputs: got ready=%b valid=%b err=%b rdata=%h ra=%h",
                      req_ready, resp_valid, resp_err, resp_rdata, mem_r_addr);
    end
    @(posedge clk); #1;
    total++;
    if (we_cnt !== wc) begin
      bad++; $display("FAIL rst_wr pulses: got %0d want %0d", we_cnt - wc, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_req("ld_after_rst", 1'b0, 32'h0001_0004, 2'b10, 1'b0, 32'h0, 32'hBEEF_3344, 1'b0, 2, 0, 0);
  endtask

`ifdef MEM_RANGE_CHECK_EN
  task automatic test_range;
    run_req("rng_hi", 1'b0, 32'h0002_0000, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    run_req("rng_lo", 1'b1, 32'h0000_FFFC, 2'b10, 1'b0, 32'h5, 32'h0, 1'b1, 1, 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_word_store();
    test_loads();
    test_subword_store();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_in_wr();
`ifdef MEM_RANGE_CHECK_EN
    test_range();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Pipeline-side load/store initiator for the byte-addressed data RAM, which has a combinational word read port and a clocked word write port.
- Accepts one byte/half/word request at a time over a valid/ready handshake.
- Word-aligns the RAM address, sign/zero-extends load data, and performs read-modify-write for sub-word stores, because the RAM port only writes whole words.
- Returns a response over a valid/ready handshake. Sits between the MEM stage and the data RAM.

Parameters:
- DATA_WIDTH, 32, data and address width.
- BYTE_WIDTH, 8, bits per addressable byte.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  DATA_WIDTH  byte address.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
- req_wdata  input  DATA_WIDTH  store data, right-justified.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  output  1  request rejected: misaligned, reserved size, or out of range.
- mem_r_addr  output  DATA_WIDTH  RAM read address, always {addr[31:2],2'b00}.
- mem_rd  input  DATA_WIDTH  RAM combinational read data.
- mem_w_addr  output  DATA_WIDTH  RAM write address, word-aligned.
- mem_wd  output  DATA_WIDTH  RAM write data.
- mem_we  output  1  RAM write enable.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0; req_ready=1 once in IDLE.
  - All captured request fields are cleared.
  - mem_we is decoded from state, so reset during WR suppresses the write immediately.
  - Reset in RD/RESP drops the request silently.
- Accept: handshake on a posedge with req_valid & req_ready. Latch we, addr, size, unsigned, wdata.
- Error check at accept, using the latched fields:
  - size=11;
  - size=01 with addr[0]=1;
  - size=10 with addr[1:0]!=0.
  - Any hit: go IDLE->RESP with resp_err=1, resp_rdata=0; no RAM access, mem_we never asserted.
- FSM states: IDLE, RD, WR, RESP.
  - Load: IDLE->RD->RESP.
  - Word store: IDLE->WR->RESP.
  - Byte/half store: IDLE->RD->WR->RESP.
- RD (one cycle):
  - mem_r_addr = aligned address.
  - mem_rd captured at the clock edge into a word register.
  - Load: extracted lane at offset addr[1:0]*8, width 8/16/32, is extended per req_unsigned into resp_rdata.
- WR (one cycle):
  - mem_we=1, mem_w_addr = aligned address.
  - mem_wd = captured word with the byte/half lane replaced by wdata[7:0] / wdata[15:0]; word store uses wdata directly.
  - The RAM commits at the end of the WR cycle.
- RESP: resp_valid=1, outputs held stable until resp_ready=1, then ->IDLE.
- Latency and throughput:
  - With resp_ready tied high: load = 3 cycles accept-to-accept; word store = 3; sub-word store = 4; error = 2.
  - req_ready=0 outside IDLE. No new request is accepted in the same cycle a response retires.
- mem_r_addr and mem_w_addr hold the latched aligned address outside IDLE and 0 in IDLE. mem_wd=0 when mem_we=0.
- Endianness is little-endian: byte at addr+0 is bits [7:0].

Optional Feature:
- Macro: MEM_RANGE_CHECK_EN.
- Defined: requests with address outside 0x00010000–0x0001FFFF, or with last byte beyond 0x0001FFFF, are treated as errors (resp_err=1, no RAM access, 2-cycle path).
- Undefined: no range check; every aligned request reaches the RAM.

Decomposition:
- Package mem_access_pkg:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_RSV);
  - state enum;
  - DATA_BASE = 32'h00010000, DATA_TOP = 32'h0001FFFF.
- One sub-module, mem_lane_align. Purely combinational; does lane extract + sign/zero-extend for loads and lane merge for stores, keyed by offset and size. It is reused by the cache later.

Test Plan:
- RAM word 0x10000 = 0x8899AABB; load byte signed addr 0x10002 -> resp_rdata=0xFFFFFF99, resp_err=0, resp_valid 2 cycles after accept.
- Same word; load half unsigned addr 0x10002 -> 0x00008899; load word 0x10000 -> 0x8899AABB.
- Store byte 0x5A at 0x10001 over 0x8899AABB -> exactly one mem_we pulse, mem_w_addr=0x10000, mem_wd=0x88995ABB; subsequent word load returns 0x88995ABB.
- Load word at 0x10002, and store half at 0x10003 -> resp_err=1, resp_rdata=0, mem_we never high, req_ready back in 2 cycles.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid/resp_rdata stable, req_ready=0 throughout; retire on resp_ready=1.
- Assert rst_n=0 during WR of a byte store -> mem_we drops immediately, RAM word unchanged, outputs at reset values. With MEM_RANGE_CHECK_EN, load word 0x00020000 -> resp_err=1.
